// File: rtl/math_pkg.sv
// ---------------------------------------------------------------------------
// math_pkg
// Shared definitions for the math library blocks:
//   state_e    - control FSM state encoding (IDLE/RUN/DONE, 2-bit)
//   cnt_width  - width for a counter that indexes n items (minimum 1 bit)
// ---------------------------------------------------------------------------
package math_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // A counter over a single item still needs one bit to be a legal vector.
   function automatic int cnt_width(input int n);
      int w;
      if (n <= 1) begin
         w = 1;
      end else begin
         w = $clog2(n);
      end
      return w;
   endfunction

endpackage

// File: rtl/math_subtractor_multicycle_if.sv
// ---------------------------------------------------------------------------
// math_subtractor_multicycle_if
// Operand/result handshake bundle of the multicycle subtractor.
//   i_valid/o_ready           - operand handshake (into the subtractor)
//   i_a, i_b, i_borrow_in     - operands
//   o_valid/i_ready           - result handshake (out of the subtractor)
//   o_difference, o_borrow_out, o_overflow - result
// slave  : subtractor side
// master : producer/consumer side
// ---------------------------------------------------------------------------
interface math_subtractor_multicycle_if #(
   parameter int N = 32
);
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic         i_borrow_in;
   logic         o_valid;
   logic         i_ready;
   logic [N-1:0] o_difference;
   logic         o_borrow_out;
   logic         o_overflow;

   modport slave (
      input  i_valid, i_a, i_b, i_borrow_in, i_ready,
      output o_ready, o_valid, o_difference, o_borrow_out, o_overflow
   );

   modport master (
      output i_valid, i_a, i_b, i_borrow_in, i_ready,
      input  o_ready, o_valid, o_difference, o_borrow_out, o_overflow
   );
endinterface

// File: rtl/math_subtractor_cla_slice.sv
// ---------------------------------------------------------------------------
// math_subtractor_cla_slice
// Combinational W-bit borrow-lookahead subtractor: difference = a - b - borrow_in.
//   a, b        - W-bit operands
//   borrow_in   - borrow into bit 0
//   difference  - W-bit result (mod 2^W)
//   borrow_out  - borrow out of bit W-1
// ---------------------------------------------------------------------------
module math_subtractor_cla_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         borrow_in,
   output logic [W-1:0] difference,
   output logic         borrow_out
);

   logic [W-1:0] gen_s;
   logic [W-1:0] prop_s;
   logic [W-1:0] grp_gen_s;
   logic [W-1:0] grp_prop_s;
   logic [W:0]   borrow_s;

   // Bit borrow generate (a=0,b=1) and propagate (a==b), group prefix terms,
   // then every borrow is formed directly from borrow_in and the group terms.
   always_comb begin
      gen_s      = ~a & b;
      prop_s     = ~(a ^ b);
      grp_gen_s  = '0;
      grp_prop_s = '0;
      borrow_s   = '0;

      grp_gen_s[0]  = gen_s[0];
      grp_prop_s[0] = prop_s[0];
      for (int i = 1; i < W; i++) begin
         grp_gen_s[i]  = gen_s[i] | (prop_s[i] & grp_gen_s[i-1]);
         grp_prop_s[i] = prop_s[i] & grp_prop_s[i-1];
      end

      borrow_s[0] = borrow_in;
      for (int i = 0; i < W; i++) begin
         borrow_s[i+1] = grp_gen_s[i] | (grp_prop_s[i] & borrow_in);
      end

      difference = a ^ b ^ borrow_s[W-1:0];
      borrow_out = borrow_s[W];
   end

endmodule

// File: rtl/math_subtractor_multicycle.sv
// ---------------------------------------------------------------------------
// math_subtractor_multicycle
// N-bit subtractor (a - b - borrow_in) that resolves CHUNK bits per clock,
// keeping the borrow path one slice long. Result appears NUM_CHUNKS clocks
// after the operands are accepted and is held until taken downstream.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus (slave)    - operand handshake in, result handshake out
// ---------------------------------------------------------------------------
module math_subtractor_multicycle
   import math_pkg::*;
#(
   parameter int N     = 32,
   parameter int CHUNK = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   math_subtractor_multicycle_if.slave   bus
);

   localparam int NUM_CHUNKS = N / CHUNK;
   localparam int CNT_W      = cnt_width(NUM_CHUNKS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   if ((CHUNK < 1) || (CHUNK > N)) begin : g_bad_chunk
      $error("math_subtractor_multicycle: CHUNK must be in 1..N");
   end else if ((N % CHUNK) != 0) begin : g_bad_multiple
      $error("math_subtractor_multicycle: N must be a multiple of CHUNK");
   end

   state_e state_q, state_d;

   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [NUM_CHUNKS-1:0][CHUNK-1:0]  a_q, a_d;
   logic [NUM_CHUNKS-1:0][CHUNK-1:0]  b_q, b_d;
   logic [NUM_CHUNKS-1:0][CHUNK-1:0]  diff_q, diff_d;
   logic                              borrow_q, borrow_d;
   logic                              valid_q, valid_d;
   logic                              bout_q, bout_d;
   logic                              ovf_q, ovf_d;

   logic                              accept_s;
   logic                              last_s;
   logic [CHUNK-1:0]                  slice_diff_s;
   logic                              slice_bout_s;

   assign accept_s = bus.i_valid && (state_q == ST_IDLE);
   assign last_s   = (cnt_q == LAST_CNT);

   math_subtractor_cla_slice #(
      .W (CHUNK)
   ) u_slice (
      .a          (a_q[cnt_q]),
      .b          (b_q[cnt_q]),
      .borrow_in  (borrow_q),
      .difference (slice_diff_s),
      .borrow_out (slice_bout_s)
   );

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.i_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: valid follows entry into DONE; flags load on the last chunk.
   always_comb begin
      valid_d = (state_d == ST_DONE);
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      if ((state_q == ST_RUN) && last_s) begin
         bout_d = slice_bout_s;
         // Operand signs differ and the result sign left the minuend's sign.
         ovf_d  = (a_q[NUM_CHUNKS-1][CHUNK-1] != b_q[NUM_CHUNKS-1][CHUNK-1]) &&
                  (slice_diff_s[CHUNK-1] != a_q[NUM_CHUNKS-1][CHUNK-1]);
      end else begin
         bout_d = bout_q;
         ovf_d  = ovf_q;
      end
   end

   // Datapath next-state: operand capture on accept, one chunk per RUN cycle.
   always_comb begin
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               a_d      = bus.i_a;
               b_d      = bus.i_b;
               borrow_d = bus.i_borrow_in;
               cnt_d    = '0;
            end else begin
               cnt_d    = cnt_q;
            end
         end
         ST_RUN: begin
            diff_d[cnt_q] = slice_diff_s;
            borrow_d      = slice_bout_s;
            if (last_s) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            cnt_d = cnt_q;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         valid_q  <= 1'b0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         valid_q  <= valid_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.o_ready      = (state_q == ST_IDLE);
   assign bus.o_valid      = valid_q;
   assign bus.o_difference = diff_q;
   assign bus.o_borrow_out = bout_q;
   assign bus.o_overflow   = ovf_q;

endmodule

// File: tb/tb_math_subtractor_multicycle.sv
// ---------------------------------------------------------------------------
// tb_math_subtractor_multicycle
// Directed and randomized checks of math_subtractor_multicycle against an
// arithmetic reference (plain wide-integer subtraction and signed range test).
// ---------------------------------------------------------------------------
module tb_math_subtractor_multicycle;

   localparam int N          = 32;
   localparam int CHUNK      = 8;
   localparam int NUM_CHUNKS = N / CHUNK;

   logic i_clk;
   logic i_rst_n;
   int   total = 0;
   int   bad   = 0;

   math_subtractor_multicycle_if #(.N(N)) bus ();

   math_subtractor_multicycle #(
      .N     (N),
      .CHUNK (CHUNK)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer subtraction; borrow when the true result is
   // negative, overflow when the signed result leaves the N-bit range.
   task automatic ref_sub(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                          output logic [N-1:0] d, output logic bo, output logic ov);
      longint ua, ub, ur, sa, sb, sr, maxv, minv;
      ua   = longint'(a);
      ub   = longint'(b);
      ur   = ua - ub - longint'(bin);
      d    = ur[N-1:0];
      bo   = (ur < 0);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      sr   = sa - sb - longint'(bin);
      maxv = (longint'(1) << (N-1)) - 1;
      minv = -(longint'(1) << (N-1));
      ov   = (sr > maxv) || (sr < minv);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         input int hold, input string tag);
      logic [N-1:0] ed;
      logic         eb, eo;
      int           cyc;
      ref_sub(a, b, bin, ed, eb, eo);
      cyc = 0;
      while ((bus.o_ready !== 1'b1) && (cyc < 50)) begin
         tick();
         cyc++;
      end
      chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
      bus.i_valid     = 1'b1;
      bus.i_a         = a;
      bus.i_b         = b;
      bus.i_borrow_in = bin;
      tick();
      bus.i_valid     = 1'b0;
      bus.i_a         = N'($urandom);
      bus.i_b         = N'($urandom);
      bus.i_borrow_in = 1'($urandom);
      cyc = 0;
      while ((bus.o_valid !== 1'b1) && (cyc < 100)) begin
         tick();
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(NUM_CHUNKS));
      chk({tag, "_diff"}, 64'(bus.o_difference), 64'(ed));
      chk({tag, "_borrow"}, 64'(bus.o_borrow_out), 64'(eb));
      chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'(eo));
      for (int h = 0; h < hold; h++) begin
         bus.i_valid     = 1'b1;
         bus.i_a         = N'($urandom);
         bus.i_b         = N'($urandom);
         bus.i_borrow_in = 1'($urandom);
         tick();
         chk({tag, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
         chk({tag, "_hold_ready"}, 64'(bus.o_ready), 64'd0);
         chk({tag, "_hold_diff"}, 64'(bus.o_difference), 64'(ed));
         chk({tag, "_hold_borrow"}, 64'(bus.o_borrow_out), 64'(eb));
         chk({tag, "_hold_ovf"}, 64'(bus.o_overflow), 64'(eo));
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      chk({tag, "_drop_valid"}, 64'(bus.o_valid), 64'd0);
      chk({tag, "_idle_ready"}, 64'(bus.o_ready), 64'd1);
   endtask

   logic [N-1:0] pick_tbl [4];
   logic [N-1:0] ra, rb;

   initial begin
      pick_tbl[0] = 32'h0000_0000;
      pick_tbl[1] = 32'hFFFF_FFFF;
      pick_tbl[2] = 32'h8000_0000;
      pick_tbl[3] = 32'h7FFF_FFFF;

      // Reset state, observed before any clock edge.
      i_rst_n         = 1'b0;
      bus.i_valid     = 1'b0;
      bus.i_ready     = 1'b0;
      bus.i_a         = '0;
      bus.i_b         = '0;
      bus.i_borrow_in = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.o_valid), 64'd0);
      chk("rst_ready", 64'(bus.o_ready), 64'd1);
      chk("rst_diff", 64'(bus.o_difference), 64'd0);
      chk("rst_borrow", 64'(bus.o_borrow_out), 64'd0);
      chk("rst_ovf", 64'(bus.o_overflow), 64'd0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();

      // Directed cases.
      run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, "small");
      run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, "chain");
      run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, "ovf_neg");
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ovf_pos");
      run_op(32'h0000_0100, 32'h0000_00FF, 1'b1, 0, "bin_zero");
      run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0, "bin_wrap");

      // Backpressure: 5 cycles of i_ready=0 with new operands offered.
      run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5, "bp");
      run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0, "after_bp");

      // Reset during the third RUN cycle.
      bus.i_valid = 1'b1;
      bus.i_a     = 32'hFFFF_0000;
      bus.i_b     = 32'h0000_FFFF;
      bus.i_borrow_in = 1'b0;
      tick();
      bus.i_valid = 1'b0;
      tick();
      tick();
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(bus.o_valid), 64'd0);
      chk("midrst_diff", 64'(bus.o_difference), 64'd0);
      chk("midrst_ready", 64'(bus.o_ready), 64'd1);
      tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < NUM_CHUNKS + 2; k++) begin
         tick();
      end
      chk("midrst_no_output", 64'(bus.o_valid), 64'd0);
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, "post_rst");

      // Randomized back-to-back operations, biased toward sign boundaries.
      for (int r = 0; r < 40; r++) begin
         ra = ($urandom_range(0, 3) == 0) ? pick_tbl[$urandom_range(0, 3)] : N'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? pick_tbl[$urandom_range(0, 3)] : N'($urandom);
         run_op(ra, rb, 1'($urandom), 0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
